fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the RV32 pipeline. It owns the PC, issues one instruction-memory request at a time over a valid/ready handshake, and loads fetched instructions into IF/ID. It consumes `PCWrite` and `Write_IFID` from the hazard detection unit and the taken-branch redirect from EX. Its IF/ID outputs feed decode and the hazard unit's `rs1_IFID`/`rs2_IFID` extraction.

---
 rtl/rv_pipe_pkg.sv | 6 +
 rtl/if_id_reg.sv | 46 ++++
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared constants and types for the RV32 pipeline front end
package rv_pipe_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {F_REQ, F_WAIT, F_HOLD, F_DROP} fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush > hold > load > bubble priority
module if_id_reg
  import rv_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic            load_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o
);
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4_q;
  logic            valid_q;
  // flush and bubble leave the PC fields alone; only a real load moves them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= XLEN'(4);
      valid_q    <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      instr_q <= load_i ? instr_i : NOP_INSTR;
      valid_q <= load_i;
      if (load_i) begin
        pc_q       <= pc_i;
        pc_plus4_q <= pc_i + XLEN'(4);
      end
    end
  end
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem fetch FSM, hold buffer and IF/ID register
module fetch_stage
  import rv_pipe_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCWrite,
  input  logic            Write_IFID,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     instr_IFID,
  output logic [XLEN-1:0] pc_IFID,
  output logic [XLEN-1:0] pc_plus4_IFID,
  output logic            valid_IFID
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     buf_q, buf_d;
  logic            ld;
  logic [31:0]     ld_instr;
  logic            advance, hs;
  logic [XLEN-1:0] pc_next;
  assign advance        = PCWrite & Write_IFID;
  assign imem_req_valid = (state_q == F_REQ) & ~rst;
  assign imem_req_addr  = pc_q;
  assign hs             = imem_req_valid & imem_req_ready;
  assign pc_next        = pc_q + XLEN'(4);
  // next state, PC and hold buffer; a redirect always wins over a stall
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_d    = buf_q;
    ld       = 1'b0;
    ld_instr = imem_rsp_data;
    unique case (state_q)
      F_REQ: begin
        if (PCSrcE) begin
          pc_d    = PCTargetE;
          state_d = hs ? F_DROP : F_REQ;
        end else if (hs) begin
          state_d = F_WAIT;
        end
      end
      F_WAIT: begin
        if (imem_rsp_valid) begin
          if (PCSrcE) begin
            pc_d    = PCTargetE;
            state_d = F_REQ;
          end else if (advance) begin
            ld      = 1'b1;
            pc_d    = pc_next;
            state_d = F_REQ;
          end else begin
            buf_d   = imem_rsp_data;
            state_d = F_HOLD;
          end
        end else if (PCSrcE) begin
          pc_d    = PCTargetE;
          state_d = F_DROP;
        end
      end
      F_HOLD: begin
        ld_instr = buf_q;
        if (PCSrcE) begin
          pc_d    = PCTargetE;
          state_d = F_REQ;
        end else if (advance) begin
          ld      = 1'b1;
          pc_d    = pc_next;
          state_d = F_REQ;
        end
      end
      F_DROP: begin
        pc_d    = PCSrcE ? PCTargetE : pc_q;
        state_d = imem_rsp_valid ? F_REQ : F_DROP;
      end
      default: state_d = F_REQ;
    endcase
  end
  // fetch FSM, PC and hold buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= F_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end
  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (PCSrcE),
    .hold_i    (~Write_IFID),
    .load_i    (ld),
    .instr_i   (ld_instr),
    .pc_i      (pc_q),
    .instr_o   (instr_IFID),
    .pc_o      (pc_IFID),
    .pc_plus4_o(pc_plus4_IFID),
    .valid_o   (valid_IFID)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against a program-order model
module tb_fetch_stage;
  import rv_pipe_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCWrite = 1'b1, Write_IFID = 1'b1, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [31:0] imem_req_addr, imem_rsp_data = '0;
  logic [31:0] instr_IFID, pc_IFID, pc_plus4_IFID;
  logic        valid_IFID;
  logic        d2_rv, d2_v;
  logic [31:0] d2_addr, d2_instr, d2_pc, d2_pc4;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .Write_IFID(Write_IFID),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_IFID(instr_IFID), .pc_IFID(pc_IFID),
    .pc_plus4_IFID(pc_plus4_IFID), .valid_IFID(valid_IFID)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .Write_IFID(Write_IFID),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req_valid(d2_rv), .imem_req_addr(d2_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_IFID(d2_instr), .pc_IFID(d2_pc),
    .pc_plus4_IFID(d2_pc4), .valid_IFID(d2_v)
  );

  int total = 0, bad = 0, loads = 0, idle = 0;
  logic pcw = 1'b1, wif = 1'b1, pcs = 1'b0, rdy = 1'b1, rdy_rand = 1'b0, lat_rand = 1'b0;
  logic [31:0] tgt = '0;
  int lat = 1;
  logic m_busy = 1'b0;
  int m_cnt = 0;
  logic [31:0] m_addr = '0, exp_pc = '0;
  logic p_rv, p_hs, p_rs, prev_chk = 1'b0;
  logic [31:0] p_ra, prev_ra, d2_ra_pre;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_valid", valid_IFID, 0);
    chk("rst_instr", instr_IFID, NOP_INSTR);
    chk("rst_pc", pc_IFID, 0);
    chk("rst_pc4", pc_plus4_IFID, 4);
    chk("rst_wrap_addr", d2_addr, 32'hFFFF_FFFC);
    pcs = 1'b0;
    PCSrcE = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_busy = 1'b0;
    exp_pc = '0;
    prev_chk = 1'b0;
    idle = 0;
  endtask

  task automatic step();
    logic [31:0] s_instr, s_pc, s_pc4;
    logic s_v;
    @(negedge clk);
    PCWrite = pcw;
    Write_IFID = wif;
    PCSrcE = pcs;
    PCTargetE = tgt;
    imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy;
    imem_rsp_valid = m_busy && m_cnt == 0;
    imem_rsp_data = mem_word(m_addr);
    #1;
    p_rv = imem_req_valid;
    p_ra = imem_req_addr;
    p_hs = p_rv && imem_req_ready;
    p_rs = imem_rsp_valid;
    d2_ra_pre = d2_addr;
    s_instr = instr_IFID;
    s_pc = pc_IFID;
    s_pc4 = pc_plus4_IFID;
    s_v = valid_IFID;
    if (p_hs) chk("one_outstanding", m_busy, 0);
    if (prev_chk && p_rv) chk("addr_stable", p_ra, prev_ra);
    prev_chk = p_rv && !p_hs && !pcs;
    prev_ra = p_ra;
    @(posedge clk);
    #1;
    if (p_rs) m_busy = 1'b0;
    if (p_hs) begin
      m_busy = 1'b1;
      m_addr = p_ra;
      m_cnt = (lat_rand ? int'($urandom_range(1, 3)) : lat) - 1;
    end else if (m_busy && m_cnt > 0) m_cnt--;
    idle++;
    if (pcs) begin
      exp_pc = tgt;
      chk("flush_valid", valid_IFID, 0);
      chk("flush_instr", instr_IFID, NOP_INSTR);
    end else if (!wif) begin
      chk("hold_instr", instr_IFID, s_instr);
      chk("hold_pc", pc_IFID, s_pc);
      chk("hold_pc4", pc_plus4_IFID, s_pc4);
      chk("hold_valid", valid_IFID, s_v);
    end else if (valid_IFID) begin
      chk("load_pc", pc_IFID, exp_pc);
      chk("load_instr", instr_IFID, mem_word(exp_pc));
      chk("load_pc4", pc_plus4_IFID, exp_pc + 4);
      chk("load_vs_req", pc_IFID, m_addr);
      exp_pc = exp_pc + 4;
      loads++;
      idle = 0;
    end else chk("bubble_instr", instr_IFID, NOP_INSTR);
    if (idle > 300) begin
      chk("progress_timeout", idle, 0);
      idle = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // reset release with a 1-cycle memory and no stalls
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rel_req_valid", p_rv, k % 2 == 0);
      if (k % 2 == 0) chk("rel_req_addr", p_ra, 4 * (k / 2));
      chk("rel_valid_pulse", valid_IFID, k % 2);
      if (k == 1) begin
        chk("wrap_pc", d2_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", d2_pc4, 0);
      end
      if (k == 2) chk("wrap_second_addr", d2_ra_pre, 0);
    end
    // load-use stall while the response lands in WAIT
    step();
    pcw = 1'b0; wif = 1'b0;
    step();
    pcw = 1'b1; wif = 1'b1;
    step();
    chk("hold_no_req", p_rv, 0);
    chk("hold_load_pc", pc_IFID, 32'hC);
    chk("hold_load_valid", valid_IFID, 1);
    step();
    chk("after_hold_req", p_rv, 1);
    chk("after_hold_addr", p_ra, 32'h10);
    step();
    // redirect while a 3-cycle request is outstanding
    lat = 3;
    step();
    pcs = 1'b1; tgt = 32'h100; lat = 1;
    step();
    pcs = 1'b0;
    step();
    chk("drop_no_req1", p_rv, 0);
    step();
    chk("drop_no_req2", p_rv, 0);
    chk("drop_stale_rsp", p_rs, 1);
    chk("drop_valid", valid_IFID, 0);
    step();
    chk("redir_req", p_rv, 1);
    chk("redir_addr", p_ra, 32'h100);
    step();
    chk("redir_land_pc", pc_IFID, 32'h100);
    chk("redir_land_valid", valid_IFID, 1);
    // redirect while in HOLD
    step();
    pcw = 1'b0; wif = 1'b0;
    step();
    pcw = 1'b1; wif = 1'b1; pcs = 1'b1; tgt = 32'h200;
    step();
    pcs = 1'b0;
    step();
    chk("hold_redir_addr", p_ra, 32'h200);
    step();
    chk("hold_redir_pc", pc_IFID, 32'h200);
    // redirect together with a full stall
    rdy = 1'b0; pcs = 1'b1; tgt = 32'h300; pcw = 1'b0; wif = 1'b0;
    step();
    chk("stall_redir_valid", valid_IFID, 0);
    pcs = 1'b0; pcw = 1'b1; wif = 1'b1;
    step();
    chk("stall_redir_addr", p_ra, 32'h300);
    rdy = 1'b1;
    step();
    step();
    chk("stall_redir_pc", pc_IFID, 32'h300);
    // reset while a request is outstanding
    step();
    do_reset();
    step();
    chk("post_rst_addr", p_ra, 0);
    // randomized traffic against the program-order model
    rdy_rand = 1'b1; lat_rand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      pcw = $urandom_range(0, 9) != 0;
      wif = $urandom_range(0, 9) != 0;
      pcs = $urandom_range(0, 11) == 0;
      tgt = 32'($urandom_range(0, 1023)) << 2;
      if (i == 300) do_reset();
      step();
    end
    chk("loads_seen", loads > 60, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
